psum_accumulator: RTL and testbench

- Sits directly downstream of the fusion-unit systolic array and consumes its bottom-row `psums` bus (one bus per column).
- Accumulates a programmed number of K-tiles of column partial sums into wide per-lane accumulators.
- Presents the finished result to the output writer over a valid/ready handshake.
- Each column's psum word is treated as 4 independent signed lanes of COL_WIDTH bits.

---
 rtl/psum_accumulator.sv | 147 ++++++++++++++
 tb/tb_psum_accumulator.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accumulator.sv
// -----------------------------------------------------------------------------
// psum_accumulator
//
// Purpose:
//   This block sits below the systolic array and takes in the bottom-row
//   column partial sums. Each column word holds 4 signed lanes of COL_WIDTH
//   bits. The block adds a programmed number of K-tiles into per-lane signed
//   accumulators that are ACC_WIDTH bits wide. It then holds the finished
//   result for the output writer until that side accepts it over a
//   valid/ready handshake.
//
// Ports:
//   clk        - clock; all logic is on the rising edge
//   reset      - synchronous, active-high; forces IDLE from any state
//   start      - begins a new job; sampled only in IDLE
//   num_tiles  - number of tiles to accumulate; 0 is treated as 1
//   psum_valid - psums holds a valid tile result this cycle
//   psum_ready - high while the block accepts psums (ACCUM only)
//   psums      - column psums; lane l of column c is psums[c][l*COL_WIDTH +: COL_WIDTH]
//   out_valid  - out_data holds a completed result (DRAIN)
//   out_ready  - downstream accepts out_data
//   out_data   - accumulator contents, in the same column/lane order as psums
//   busy       - high whenever the block is not IDLE
//   overflow   - sticky per job; set if any lane addition overflowed
// -----------------------------------------------------------------------------
module psum_accumulator #(
    parameter int ARRAY_SIZE     = 8,
    parameter int LOG_ARRAY_SIZE = 3,
    parameter int COL_WIDTH      = 10 + LOG_ARRAY_SIZE,
    parameter int ACC_WIDTH      = 32   // must be >= COL_WIDTH + 8
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         start,
    input  logic [7:0]                                   num_tiles,
    input  logic                                         psum_valid,
    output logic                                         psum_ready,
    input  logic [ARRAY_SIZE-1:0][4*COL_WIDTH-1:0]       psums,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [ARRAY_SIZE-1:0][3:0][ACC_WIDTH-1:0]    out_data,
    output logic                                         busy,
    output logic                                         overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                                       state_q, state_d;
    logic [ARRAY_SIZE-1:0][3:0][ACC_WIDTH-1:0]    acc_q, acc_d;
    logic [7:0]                                   cnt_q, cnt_d;
    logic [7:0]                                   target_q, target_d;
    logic                                         ovf_q, ovf_d;

    // Per-lane candidate sums and overflow flags. Every lane is computed in
    // every cycle. The control logic decides whether the sums get committed.
    logic [ARRAY_SIZE-1:0][3:0][ACC_WIDTH-1:0]    lane_sum;
    logic [ARRAY_SIZE-1:0][3:0]                   lane_ovf;

    genvar gi, gl;
    generate
        for (gi = 0; gi < ARRAY_SIZE; gi++) begin : g_col
            for (gl = 0; gl < 4; gl++) begin : g_lane
                logic [COL_WIDTH-1:0] lane_in;
                logic [ACC_WIDTH-1:0] lane_ext;

                assign lane_in  = psums[gi][gl*COL_WIDTH +: COL_WIDTH];
                assign lane_ext = {{(ACC_WIDTH-COL_WIDTH){lane_in[COL_WIDTH-1]}}, lane_in};
                assign lane_sum[gi][gl] = acc_q[gi][gl] + lane_ext;

                // Signed overflow: both addends have the same sign, but the
                // wrapped sum has the opposite sign.
                assign lane_ovf[gi][gl] =
                    (acc_q[gi][gl][ACC_WIDTH-1] == lane_ext[ACC_WIDTH-1]) &&
                    (lane_sum[gi][gl][ACC_WIDTH-1] != acc_q[gi][gl][ACC_WIDTH-1]);
            end
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    target_d = (num_tiles == 8'd0) ? 8'd1 : num_tiles;
                    acc_d    = '0;
                    cnt_d    = 8'd0;
                    ovf_d    = 1'b0;
                    state_d  = ACCUM;
                end
            end
            ACCUM: begin
                // psum_ready is high for the whole of ACCUM, so psum_valid
                // alone signals a transfer.
                if (psum_valid) begin
                    acc_d = lane_sum;
                    cnt_d = cnt_q + 8'd1;
                    ovf_d = ovf_q | (|lane_ovf);
                    if ((cnt_q + 8'd1) == target_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= 8'd0;
            target_q <= 8'd1;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            ovf_q    <= ovf_d;
        end
    end

    // All outputs are decoded from registered state, so none of them has a
    // combinational path from an input.
    assign psum_ready = (state_q == ACCUM);
    assign out_valid  = (state_q == DRAIN);
    assign busy       = (state_q != IDLE);
    assign out_data   = acc_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_psum_accumulator.sv
module tb_psum_accumulator;

    localparam int AS = 8;
    localparam int CW = 13;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        start;
    logic [7:0]                  num_tiles;
    logic                        psum_valid;
    logic [AS-1:0][4*CW-1:0]     psums_in;
    logic                        out_ready;

    logic                        psum_ready, out_valid, busy, overflow;
    logic [AS-1:0][3:0][31:0]    out_data;
    logic                        psum_ready16, out_valid16, busy16, overflow16;
    logic [AS-1:0][3:0][15:0]    out_data16;

    always #5 clk = ~clk;

    psum_accumulator #(.ACC_WIDTH(32)) u_dut (
        .clk(clk), .reset(reset), .start(start), .num_tiles(num_tiles),
        .psum_valid(psum_valid), .psum_ready(psum_ready), .psums(psums_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .overflow(overflow)
    );

    psum_accumulator #(.ACC_WIDTH(16)) u_dut16 (
        .clk(clk), .reset(reset), .start(start), .num_tiles(num_tiles),
        .psum_valid(psum_valid), .psum_ready(psum_ready16), .psums(psums_in),
        .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16),
        .busy(busy16), .overflow(overflow16)
    );

    // Reference model: plain integer sums per lane plus the job bookkeeping.
    longint exp32 [AS][4];
    longint exp16 [AS][4];
    bit     ovf32_m, ovf16_m;
    int     target_m, done_m;
    bit     fixed_data;
    bit     valid_pat[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic longint wrapn(input longint x, input int w);
        longint r;
        r = x & ((longint'(1) << w) - 1);
        if (r >= (longint'(1) << (w - 1))) r = r - (longint'(1) << w);
        return r;
    endfunction

    function automatic logic [AS*4*32-1:0] pack32();
        logic [AS*4*32-1:0] v;
        logic [63:0] t;
        for (int c = 0; c < AS; c++)
            for (int l = 0; l < 4; l++) begin
                t = exp32[c][l];
                v[(c*4+l)*32 +: 32] = t[31:0];
            end
        return v;
    endfunction

    function automatic logic [AS*4*16-1:0] pack16();
        logic [AS*4*16-1:0] v;
        logic [63:0] t;
        for (int c = 0; c < AS; c++)
            for (int l = 0; l < 4; l++) begin
                t = exp16[c][l];
                v[(c*4+l)*16 +: 16] = t[15:0];
            end
        return v;
    endfunction

    task automatic chk_data(input string tag);
        logic [AS*4*32-1:0] e32;
        logic [AS*4*16-1:0] e16;
        e32 = pack32();
        e16 = pack16();
        n_tests++;
        assert (out_data === e32) else begin
            n_fail++;
            $error("FAIL %s_acc32: observed %h expected %h", tag, out_data, e32);
        end
        n_tests++;
        assert (out_data16 === e16) else begin
            n_fail++;
            $error("FAIL %s_acc16: observed %h expected %h", tag, out_data16, e16);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < AS; c++)
            for (int l = 0; l < 4; l++) begin
                exp32[c][l] = 0;
                exp16[c][l] = 0;
            end
        ovf32_m = 0;
        ovf16_m = 0;
        done_m  = 0;
    endtask

    task automatic model_add();
        logic signed [CW-1:0] lv;
        longint v, t;
        for (int c = 0; c < AS; c++)
            for (int l = 0; l < 4; l++) begin
                lv = psums_in[c][l*CW +: CW];
                v  = lv;
                t  = exp32[c][l] + v;
                if (t > 64'sd2147483647 || t < -64'sd2147483648) ovf32_m = 1;
                exp32[c][l] = wrapn(t, 32);
                t  = exp16[c][l] + v;
                if (t > 32767 || t < -32768) ovf16_m = 1;
                exp16[c][l] = wrapn(t, 16);
            end
        done_m++;
    endtask

    task automatic set_all_lanes(input logic [CW-1:0] v);
        for (int c = 0; c < AS; c++)
            for (int l = 0; l < 4; l++)
                psums_in[c][l*CW +: CW] = v;
    endtask

    task automatic randomize_psums();
        for (int c = 0; c < AS; c++)
            psums_in[c] = (4*CW)'({$urandom(), $urandom()});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        target_m = 1;
    endtask

    task automatic chk_idle_after_reset(input string tag);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_out_valid"}, out_valid, 1'b0);
        chk1({tag, "_psum_ready"}, psum_ready, 1'b0);
        chk1({tag, "_overflow"}, overflow, 1'b0);
        chk_data(tag);
    endtask

    task automatic start_job(input int n);
        start     = 1'b1;
        num_tiles = 8'(n);
        tick();
        start     = 1'b0;
        model_clear();
        target_m  = (n == 0) ? 1 : n;
        chk1("start_busy", busy, 1'b1);
        chk1("start_psum_ready", psum_ready, 1'b1);
        chk1("start_ovf_clear", overflow, 1'b0);
        chk_data("start_clear");
    endtask

    task automatic transfer_one();
        psum_valid = 1'b1;
        tick();
        psum_valid = 1'b0;
        model_add();
    endtask

    task automatic accum();
        int cyc;
        cyc = 0;
        while (done_m < target_m) begin
            if (valid_pat.size() > 0) psum_valid = valid_pat.pop_front();
            else psum_valid = ($urandom_range(99) < 70);
            if (!fixed_data) randomize_psums();
            tick();
            cyc++;
            if (psum_valid) model_add();
            if (done_m == target_m) begin
                chk1("out_valid_latency", out_valid, 1'b1);
            end else begin
                chk1("psum_ready_accum", psum_ready, 1'b1);
                chk1("out_valid_accum", out_valid, 1'b0);
            end
            if (cyc > 400) begin
                chk1("accum_timeout", out_valid, 1'b1);
                break;
            end
        end
        psum_valid = 1'b0;
    endtask

    task automatic drain(input int stall, input bit start_on_hs);
        chk1("drain_ovf32", overflow, ovf32_m);
        chk1("drain_ovf16", overflow16, ovf16_m);
        chk_data("drain_result");
        out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            tick();
            chk1("stall_out_valid", out_valid, 1'b1);
            chk1("stall_psum_ready", psum_ready, 1'b0);
            chk_data("stall_hold");
        end
        out_ready = 1'b1;
        start     = start_on_hs;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        chk1("post_hs_out_valid", out_valid, 1'b0);
        chk1("post_hs_busy", busy, 1'b0);
        chk1("post_hs_ovf_kept", overflow, ovf32_m);
        chk_data("post_hs_keep");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        num_tiles  = 8'd0;
        psum_valid = 1'b0;
        out_ready  = 1'b0;
        psums_in   = '0;
        fixed_data = 1'b0;
        model_clear();
        target_m = 1;
        tick();
        tick();
        reset = 1'b0;
        chk_idle_after_reset("reset");

        // Basic accumulate: every lane of column c carries c+1, 3 tiles.
        for (int c = 0; c < AS; c++)
            for (int l = 0; l < 4; l++)
                psums_in[c][l*CW +: CW] = CW'(c + 1);
        fixed_data = 1'b1;
        start_job(3);
        valid_pat = '{1, 1, 1};
        accum();
        chkw("basic_col7_lane2", out_data[7][2], 32'd24);
        chkw("basic_col0_lane0", out_data[0][0], 32'd3);
        drain(0, 1'b0);

        // Signed lanes with num_tiles=0 (one tile).
        psums_in = '0;
        for (int c = 0; c < AS; c++) begin
            psums_in[c][0*CW +: CW] = 13'h1FFF;
            psums_in[c][3*CW +: CW] = 13'h0FFF;
        end
        start_job(0);
        valid_pat = '{1};
        accum();
        chkw("signed_lane0", out_data[4][0], 32'hFFFF_FFFF);
        chkw("signed_lane3", out_data[4][3], 32'h0000_0FFF);
        drain(0, 1'b0);

        // Bubbles on psum_valid, then 5 cycles of backpressure.
        fixed_data = 1'b0;
        start_job(4);
        valid_pat = '{1, 0, 0, 1, 1, 0, 1};
        accum();
        drain(5, 1'b0);

        // Overflow on the 16-bit build: 5 tiles fit, 9 tiles wrap.
        fixed_data = 1'b1;
        set_all_lanes(13'd4095);
        start_job(5);
        accum();
        chkw("ovf5_lane", 32'(out_data16[2][1]), 32'd20475);
        chk1("ovf5_flag16", overflow16, 1'b0);
        drain(0, 1'b0);
        start_job(9);
        accum();
        chkw("ovf9_lane", 32'(out_data16[2][1]), 32'h0000_8FF7);
        chk1("ovf9_flag16", overflow16, 1'b1);
        chk1("ovf9_flag32", overflow, 1'b0);
        drain(2, 1'b0);
        chk1("ovf_kept_idle", overflow16, 1'b1);
        start_job(1);
        chk1("ovf_cleared16", overflow16, 1'b0);
        accum();
        drain(0, 1'b0);

        // start is ignored during ACCUM and on the DRAIN handshake.
        fixed_data = 1'b0;
        randomize_psums();
        start_job(4);
        start = 1'b1;
        transfer_one();
        chk_data("start_in_accum_xfer");
        start = 1'b1;
        tick();
        start = 1'b0;
        chk1("start_in_accum_busy", busy, 1'b1);
        chk_data("start_in_accum_idle_cycle");
        accum();
        drain(1, 1'b1);
        tick();
        chk1("no_restart_busy", busy, 1'b0);
        chk_data("no_restart_data");

        // Reset in the middle of ACCUM.
        start_job(4);
        randomize_psums();
        transfer_one();
        randomize_psums();
        transfer_one();
        do_reset();
        chk_idle_after_reset("reset_accum");
        start_job(4);
        accum();
        drain(0, 1'b0);

        // Reset during DRAIN.
        start_job(2);
        accum();
        do_reset();
        chk_idle_after_reset("reset_drain");

        // Randomized jobs.
        for (int j = 0; j < 12; j++) begin
            start_job($urandom_range(6));
            accum();
            drain($urandom_range(3), 1'b0);
            if ($urandom_range(1) == 1) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
